// File: rtl/mips_pkg.sv
// Shared MIPS-32 pipeline types and encodings; pure declarations, no timing.
// Opcode/funct constants are what ID uses to derive the class flags fed to the hazard unit.
package mips_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LW      = 6'h23;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // Snapshot of the instruction currently occupying EX.
    typedef struct packed {
        logic       valid;
        logic       wr_en;
        logic [4:0] wr_reg;
        logic       is_load;
    } ex_entry_t;

    // A source read hits a destination only when it is really read.
    function automatic logic src_hit(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage decode fields and EX resolve in, IF/ID/EX pipeline controls out.
// master = decode/pipeline side driving the fields, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_wr_en;
    logic [4:0] id_wr_reg;
    logic       id_is_load;
    logic       id_is_muldiv;
    logic       id_reads_hilo;
    logic       id_is_jump;
    logic       ex_branch_taken;

    logic       stall;
    logic       jump_cs;
    logic       flush_ifid;
    logic       bubble_idex;
    logic       muldiv_start;
    logic       md_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_wr_reg,
               id_is_load, id_is_muldiv, id_reads_hilo, id_is_jump, ex_branch_taken,
        input  stall, jump_cs, flush_ifid, bubble_idex, muldiv_start, md_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_wr_reg,
               id_is_load, id_is_muldiv, id_reads_hilo, id_is_jump, ex_branch_taken,
        output stall, jump_cs, flush_ifid, bubble_idex, muldiv_start, md_busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// MUL/DIV occupancy sequencer: md_busy rises the cycle after start and stays high MULDIV_LAT cycles.
// No backpressure; start while busy is ignored since the hazard unit never issues one then.
module muldiv_seq
    import mips_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic md_busy
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(MULDIV_LAT - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage MIPS hazard/control sequencer: same-cycle stall/redirect/flush decisions from ID + EX state.
// Stalls hold IF/ID and bubble ID/EX on load-use or MUL/DIV interlock; a taken branch overrides everything.
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);

    ex_entry_t ex_q;
    logic      md_busy_w;
    logic      load_use;
    logic      md_hazard;
    logic      issue;
    logic      stall_c, jump_cs_c, flush_ifid_c, bubble_idex_c;

    // Forwarding covers ALU results; only a load still in EX is too late to forward.
    assign load_use = hz.id_valid & ex_q.valid & ex_q.is_load & ex_q.wr_en
                    & (ex_q.wr_reg != REG_ZERO)
                    & (src_hit(hz.id_uses_rs, hz.id_rs, ex_q.wr_reg)
                     | src_hit(hz.id_uses_rt, hz.id_rt, ex_q.wr_reg));

    assign md_hazard = hz.id_valid & md_busy_w & (hz.id_is_muldiv | hz.id_reads_hilo);

    always_comb begin
        stall_c       = 1'b0;
        jump_cs_c     = 1'b0;
        flush_ifid_c  = 1'b0;
        bubble_idex_c = 1'b0;
        if (hz.ex_branch_taken) begin
            jump_cs_c     = 1'b1;
            flush_ifid_c  = 1'b1;
            bubble_idex_c = 1'b1;
        end else if (load_use || md_hazard) begin
            stall_c       = 1'b1;
            bubble_idex_c = 1'b1;
        end else if (hz.id_valid && hz.id_is_jump) begin
            jump_cs_c    = 1'b1;
            flush_ifid_c = 1'b1;
        end
    end

    assign issue = hz.id_valid & ~stall_c & ~hz.ex_branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (issue) begin
            ex_q.valid   <= 1'b1;
            ex_q.wr_en   <= hz.id_wr_en;
            ex_q.wr_reg  <= hz.id_wr_reg;
            ex_q.is_load <= hz.id_is_load;
        end else begin
            ex_q.valid <= 1'b0;
        end
    end

    muldiv_seq #(
        .MULDIV_LAT (MULDIV_LAT),
        .CNT_W      (CNT_W)
    ) u_muldiv_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (hz.muldiv_start),
        .md_busy (md_busy_w)
    );

    assign hz.stall        = stall_c;
    assign hz.jump_cs      = jump_cs_c;
    assign hz.flush_ifid   = flush_ifid_c;
    assign hz.bubble_idex  = bubble_idex_c;
    assign hz.muldiv_start = issue & hz.id_is_muldiv;
    assign hz.md_busy      = md_busy_w;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; observed word is {stall, jump_cs, flush_ifid, bubble_idex, muldiv_start, md_busy}.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .MULDIV_LAT (4),
        .CNT_W      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    logic [5:0] obs;
    assign obs = {hz.stall, hz.jump_cs, hz.flush_ifid, hz.bubble_idex, hz.muldiv_start, hz.md_busy};

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic we,
                         input logic [4:0] wr, input logic ld, input logic md,
                         input logic hl, input logic jp, input logic br);
        hz.id_valid        = v;
        hz.id_rs           = rs;
        hz.id_rt           = rt;
        hz.id_uses_rs      = urs;
        hz.id_uses_rt      = urt;
        hz.id_wr_en        = we;
        hz.id_wr_reg       = wr;
        hz.id_is_load      = ld;
        hz.id_is_muldiv    = md;
        hz.id_reads_hilo   = hl;
        hz.id_is_jump      = jp;
        hz.ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check mid-cycle, then step past the next rising edge.
    task automatic cyc(input string tag, input logic [5:0] exp);
        @(negedge clk);
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        @(negedge clk);
        check("rst_hold", obs, 6'b000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("post_rst", 6'b000000);

        // LW r5 ; ADD r6,r5,r1 -> one stall cycle, then issue
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0, 0); cyc("lw_r5", 6'b000000);
        drive(1, 5'd5, 5'd1, 1, 1, 1, 5'd6, 0, 0, 0, 0, 0); cyc("lu_stall", 6'b100100);
        cyc("lu_issue", 6'b000000);

        // Load to r0 never interlocks
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 1, 0, 0, 0, 0); cyc("lw_r0", 6'b000000);
        drive(1, 5'd0, 5'd0, 1, 1, 1, 5'd2, 0, 0, 0, 0, 0); cyc("r0_nostall", 6'b000000);

        // rt match only counts when rt is actually read
        drive(1, 5'd2, 5'd0, 1, 0, 1, 5'd7, 1, 0, 0, 0, 0); cyc("lw_r7_a", 6'b000000);
        drive(1, 5'd3, 5'd7, 1, 0, 1, 5'd9, 0, 0, 0, 0, 0); cyc("rt_unused", 6'b000000);
        drive(1, 5'd2, 5'd0, 1, 0, 1, 5'd7, 1, 0, 0, 0, 0); cyc("lw_r7_b", 6'b000000);
        drive(1, 5'd3, 5'd7, 1, 1, 1, 5'd9, 0, 0, 0, 0, 0); cyc("rt_stall", 6'b100100);
        cyc("rt_issue", 6'b000000);

        // JAL: redirect + flush, no stall; JAL in EX is not a load
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd31, 0, 0, 0, 1, 0); cyc("jump", 6'b011000);
        drive(1, 5'd31, 5'd0, 1, 0, 1, 5'd10, 0, 0, 0, 0, 0); cyc("after_jump", 6'b000000);

        // JR behind a dependent load: stall first, then redirect
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd9, 1, 0, 0, 0, 0); cyc("lw_r9", 6'b000000);
        drive(1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, 1, 0); cyc("jr_stall", 6'b100100);
        cyc("jr_go", 6'b011000);

        // MULT then MFLO: 4 busy/stall cycles, MFLO issues on the 5th
        drive(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, 1, 0, 0, 0); cyc("mult_start", 6'b000010);
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd8, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc("md_stall", 6'b100101);
        cyc("mflo_issue", 6'b000000);

        // Branch beats load-use; the squashed ID leaves EX empty
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd4, 1, 0, 0, 0, 0); cyc("lw_r4", 6'b000000);
        drive(1, 5'd4, 5'd0, 1, 0, 1, 5'd6, 0, 0, 0, 0, 1); cyc("br_win", 6'b011100);
        drive(1, 5'd4, 5'd0, 1, 0, 1, 5'd6, 0, 0, 0, 0, 0); cyc("br_flushed", 6'b000000);

        // Branch squashes a MULT in ID: no start pulse
        drive(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, 1, 0, 0, 1); cyc("br_mult", 6'b011100);
        idle(); cyc("br_no_md", 6'b000000);

        // Reset while MD_BUSY with md_cnt == 2
        drive(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, 1, 0, 0, 0); cyc("mult2_start", 6'b000010);
        idle(); cyc("busy_cnt3", 6'b000001);
        @(negedge clk);
        check("busy_cnt2", obs, 6'b000001);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid", obs, 6'b000000);
        @(posedge clk);
        #1;
        check("rst_mid_edge", obs, 6'b000000);
        rst_n = 1'b1;
        cyc("post_rst2", 6'b000000);

        drive(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, 1, 0, 0, 0); cyc("mult3_start", 6'b000010);
        idle();
        for (int i = 0; i < 4; i++) cyc("md_window", 6'b000001);
        cyc("md_done", 6'b000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
